// File: rtl/sph_pair_engine.sv
// sph_pair_engine: streaming SPH pair-term engine. Evaluates a fixed-point
// 1-D kernel for each (i, j) pair term and accumulates one result per task,
// either as a density sum or as a pressure-force sum.
// Optional build macro SPH_PAIR_SATURATE_EN: when defined, the accumulator
// clamps at the signed ACC_WIDTH limits on overflow; otherwise it wraps.
// overflow is raised in both builds.
module sph_pair_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int H           = 256,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          term_valid,
  output logic                          term_ready,
  input  logic                          term_first,
  input  logic                          term_last,
  input  logic [1:0]                    task_type,
  input  logic [DATA_WIDTH*5-1:0]       data_in,
  output logic signed [ACC_WIDTH-1:0]   result,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [1:0]                    result_type,
  output logic [COUNT_WIDTH-1:0]        result_count,
  output logic                          terms_in_flight,
  output logic                          overflow,
  output logic                          proto_err
);

  localparam int DW  = DATA_WIDTH;
  localparam int QW  = DW + 1;              // kernel distance / pressure-sum width
  localparam int PW  = 2 * QW;              // q*q
  localparam int WW  = PW - FRAC_BITS;      // density weight after rescale
  localparam int GW  = QW + DW;             // q*inv_rho
  localparam int GGW = GW - FRAC_BITS;      // gradient factor after rescale
  localparam int FW  = QW + GGW + 1;        // s*g
  localparam int TW  = FW - FRAC_BITS;      // force term after rescale
  localparam int AW1 = ACC_WIDTH + 1;

  localparam logic [QW-1:0] H_Q = QW'(H);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t state;
  logic   tag;

  logic signed [DW-1:0] x_i, x_j, p_i, p_j;
  logic [DW-1:0]        inv_rho;

  assign x_i     = data_in[5*DW-1 -: DW];
  assign x_j     = data_in[4*DW-1 -: DW];
  assign p_i     = data_in[3*DW-1 -: DW];
  assign p_j     = data_in[2*DW-1 -: DW];
  assign inv_rho = data_in[DW-1:0];

  logic accept, open_task, take, entry_tag;

  // A first-flagged term always opens a fresh task and flips the tag so that
  // any terms still in the pipeline from an aborted task are ignored.
  assign accept    = term_valid && term_ready;
  assign open_task = accept && term_first;
  assign take      = accept && (term_first || state == ACCUM);
  assign entry_tag = open_task ? ~tag : tag;

  logic signed [QW-1:0] d;
  logic [QW-1:0]        d_u, a, q;

  assign d   = $signed({x_i[DW-1], x_i}) - $signed({x_j[DW-1], x_j});
  assign d_u = d;
  assign a   = d[QW-1] ? (QW'(0) - d_u) : d_u;
  assign q   = (a >= H_Q) ? '0 : (H_Q - a);

  logic              s1_valid, s1_tag, s1_neg, s1_zero;
  logic [1:0]        s1_type;
  logic [QW-1:0]     s1_q;
  logic signed [DW-1:0] s1_p_i, s1_p_j;
  logic [DW-1:0]     s1_inv;

  logic [PW-1:0]        qq;
  logic [GW-1:0]        qg;
  logic signed [QW-1:0] psum;

  assign qq   = s1_q * s1_q;
  assign qg   = s1_q * s1_inv;
  assign psum = $signed({s1_p_i[DW-1], s1_p_i}) + $signed({s1_p_j[DW-1], s1_p_j});

  logic              s2_valid, s2_tag, s2_neg, s2_zero;
  logic [1:0]        s2_type;
  logic [WW-1:0]     s2_w;
  logic [GGW-1:0]    s2_g;
  logic signed [QW-1:0] s2_s;

  logic signed [FW-1:0] prod;
  logic signed [TW-1:0] fsh, fsel;

  assign prod = s2_s * $signed({1'b0, s2_g});
  assign fsh  = prod[FW-1:FRAC_BITS];

  // Select the per-type contribution; reserved types add nothing.
  always_comb begin
    fsel = '0;
    case (s2_type)
      2'd0:    fsel = $signed({{(TW-WW){1'b0}}, s2_w});
      2'd1:    fsel = s2_zero ? '0 : (s2_neg ? -fsh : fsh);
      default: fsel = '0;
    endcase
  end

  logic                  s3_valid, s3_tag;
  logic signed [AW1-1:0] s3_term;

  logic unused_bits;
  assign unused_bits = ^{prod[FRAC_BITS-1:0], qq[FRAC_BITS-1:0], qg[FRAC_BITS-1:0], fsel[TW-1:AW1]};

  assign terms_in_flight = s1_valid || s2_valid || s3_valid;

  // Three-stage kernel pipeline, one term per cycle.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0; s1_tag <= 1'b0; s1_neg <= 1'b0; s1_zero <= 1'b0;
      s1_type  <= '0;   s1_q   <= '0;   s1_p_i <= '0;   s1_p_j  <= '0; s1_inv <= '0;
      s2_valid <= 1'b0; s2_tag <= 1'b0; s2_neg <= 1'b0; s2_zero <= 1'b0;
      s2_type  <= '0;   s2_w   <= '0;   s2_g   <= '0;   s2_s    <= '0;
      s3_valid <= 1'b0; s3_tag <= 1'b0; s3_term <= '0;
    end else begin
      s1_valid <= take;
      s1_tag   <= entry_tag;
      s1_type  <= open_task ? task_type : result_type;
      s1_neg   <= d[QW-1];
      s1_zero  <= (d == '0);
      s1_q     <= q;
      s1_p_i   <= p_i;
      s1_p_j   <= p_j;
      s1_inv   <= inv_rho;

      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      s2_type  <= s1_type;
      s2_neg   <= s1_neg;
      s2_zero  <= s1_zero;
      s2_w     <= qq[PW-1:FRAC_BITS];
      s2_g     <= qg[GW-1:FRAC_BITS];
      s2_s     <= psum;

      s3_valid <= s2_valid;
      s3_tag   <= s2_tag;
      s3_term  <= fsel[AW1-1:0];
    end
  end

  logic signed [AW1-1:0]       sum;
  logic                        sum_ovf, acc_en;
  logic signed [ACC_WIDTH-1:0] acc_next;

  assign sum     = $signed({result[ACC_WIDTH-1], result}) + s3_term;
  assign sum_ovf = sum[AW1-1] ^ sum[AW1-2];
  assign acc_en  = s3_valid && (s3_tag == tag);

`ifdef SPH_PAIR_SATURATE_EN
  assign acc_next = sum_ovf ? (sum[AW1-1] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
`else
  assign acc_next = sum[ACC_WIDTH-1:0];
`endif

  // Task control FSM with the accumulator, counter and result registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      term_ready   <= 1'b1;
      result_valid <= 1'b0;
      result       <= '0;
      result_type  <= '0;
      result_count <= '0;
      overflow     <= 1'b0;
      proto_err    <= 1'b0;
      tag          <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      if (acc_en) begin
        result <= acc_next;
        if (sum_ovf) overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept && !term_first) proto_err <= 1'b1;
        end
        ACCUM: begin
          if (accept) begin
            if (term_first) proto_err <= 1'b1;
            else result_count <= result_count + COUNT_WIDTH'(1);
            if (term_last) begin
              state      <= DRAIN;
              term_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!terms_in_flight) begin
            state        <= HOLD;
            result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            term_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (open_task) begin
        result       <= '0;
        overflow     <= 1'b0;
        result_count <= COUNT_WIDTH'(1);
        result_type  <= task_type;
        tag          <= ~tag;
        state        <= term_last ? DRAIN : ACCUM;
        term_ready   <= !term_last;
      end
    end
  end

endmodule

// File: tb/tb_sph_pair_engine.sv
// tb_sph_pair_engine: directed and randomized checks of sph_pair_engine
// against a plain-arithmetic kernel/accumulator model. A second instance with
// a 16-bit accumulator shares all inputs and is used for the overflow cases.
module tb_sph_pair_engine;

  localparam int DW  = 16;
  localparam int ACC = 24;
  localparam int CW  = 10;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst, term_valid, term_first, term_last, result_ready;
  logic [1:0]        task_type;
  logic [DW*5-1:0]   data_in;

  logic              term_ready, result_valid, terms_in_flight, overflow, proto_err;
  logic signed [ACC-1:0] result;
  logic [1:0]        result_type;
  logic [CW-1:0]     result_count;

  logic              s_term_ready, s_result_valid, s_terms_in_flight, s_overflow, s_proto_err;
  logic signed [15:0] s_result;
  logic [1:0]        s_result_type;
  logic [CW-1:0]     s_result_count;

  sph_pair_engine dut (
    .clk_in(clk_in), .rst(rst), .term_valid(term_valid), .term_ready(term_ready),
    .term_first(term_first), .term_last(term_last), .task_type(task_type),
    .data_in(data_in), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .result_type(result_type),
    .result_count(result_count), .terms_in_flight(terms_in_flight),
    .overflow(overflow), .proto_err(proto_err)
  );

  sph_pair_engine #(.ACC_WIDTH(16)) dut16 (
    .clk_in(clk_in), .rst(rst), .term_valid(term_valid), .term_ready(s_term_ready),
    .term_first(term_first), .term_last(term_last), .task_type(task_type),
    .data_in(data_in), .result(s_result), .result_valid(s_result_valid),
    .result_ready(result_ready), .result_type(s_result_type),
    .result_count(s_result_count), .terms_in_flight(s_terms_in_flight),
    .overflow(s_overflow), .proto_err(s_proto_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit       is_first;
    bit       is_last;
    logic [1:0] ttype;
    int       xi, xj, pi, pj, inv;
  } term_t;

  term_t tq[$];

  function automatic term_t mk(bit f, bit l, int ty, int xi, int xj, int pi, int pj, int inv);
    term_t t;
    t.is_first = f; t.is_last = l; t.ttype = 2'(ty);
    t.xi = xi; t.xj = xj; t.pi = pi; t.pj = pj; t.inv = inv;
    return t;
  endfunction

  // Kernel contribution of one pair, straight from the fixed-point formulas
  // with H = 1.0 = 256 and 8 fractional bits.
  function automatic longint term_val(logic [1:0] ty, int xi, int xj, int pi, int pj, int inv);
    longint dd, aa, qv, s, g, f;
    dd = longint'(xi) - longint'(xj);
    aa = (dd < 0) ? -dd : dd;
    qv = (aa >= 256) ? 0 : 256 - aa;
    if (ty == 2'd0) return (qv * qv) / 256;
    if (ty == 2'd1) begin
      s = longint'(pi) + longint'(pj);
      g = (qv * longint'(inv)) / 256;
      f = (s * g) >>> 8;
      if (dd < 0) f = -f;
      if (dd == 0) f = 0;
      return f;
    end
    return 0;
  endfunction

  function automatic void add_model(input longint term, input int w, inout longint acc, inout bit ovf);
    longint s, mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    s  = acc + term;
    if (s > mx || s < mn) begin
      ovf = 1'b1;
`ifdef SPH_PAIR_SATURATE_EN
      s = (s > mx) ? mx : mn;
`else
      s = (s > mx) ? s - (longint'(1) <<< w) : s + (longint'(1) <<< w);
`endif
    end
    acc = s;
  endfunction

  function automatic void model_task(input int w, output longint res, output bit ovf);
    res = 0;
    ovf = 1'b0;
    foreach (tq[i])
      add_model(term_val(tq[0].ttype, tq[i].xi, tq[i].xj, tq[i].pi, tq[i].pj, tq[i].inv), w, res, ovf);
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offer one term and return #1 after the edge that accepts it.
  task automatic applyStimulus(input term_t t);
    int guard;
    term_first = t.is_first;
    term_last  = t.is_last;
    task_type  = t.ttype;
    data_in    = {DW'(t.xi), DW'(t.xj), DW'(t.pi), DW'(t.pj), DW'(t.inv)};
    term_valid = 1'b1;
    guard = 0;
    while (!term_ready && guard < 50) begin
      @(posedge clk_in); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("accept_timeout", term_ready, 1);
    @(posedge clk_in); #1;
    term_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!result_valid && cyc < 100) begin
      @(posedge clk_in); #1;
      cyc++;
    end
  endtask

  task automatic release_result(input string name);
    result_ready = 1'b1;
    @(posedge clk_in); #1;
    result_ready = 1'b0;
    checkOutput({name, "_rv_fall"}, result_valid, 0);
    checkOutput({name, "_ready_back"}, term_ready, 1);
  endtask

  // Send the queued task, then check the result against the model.
  task automatic run_queue(input string name, input bit gaps, input bit abort,
                           input bit chk16, input bit use_const, input longint exp_const);
    int cyc;
    longint exp_res;
    bit exp_ovf;
    foreach (tq[i]) begin
      applyStimulus(tq[i]);
      checkOutput({name, "_proto"}, proto_err, (i == 0 && abort) ? 1 : 0);
      if (gaps && !tq[i].is_last) repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
    end
    checkOutput({name, "_drain_ready"}, term_ready, 0);
    wait_result(cyc);
    checkOutput({name, "_latency"}, cyc, 4);
    model_task(ACC, exp_res, exp_ovf);
    checkOutput({name, "_result"}, result, exp_res);
    checkOutput({name, "_count"}, result_count, tq.size() % (1 << CW));
    checkOutput({name, "_type"}, result_type, tq[0].ttype);
    checkOutput({name, "_ovf"}, overflow, exp_ovf);
    if (use_const) checkOutput({name, "_directed"}, result, exp_const);
    if (chk16) begin
      model_task(16, exp_res, exp_ovf);
      checkOutput({name, "_r16"}, s_result, exp_res);
      checkOutput({name, "_ovf16"}, s_overflow, exp_ovf);
    end
    release_result(name);
  endtask

  initial begin
    int cyc;
    int n;
    int xi;
    bit seen;

    rst = 1'b0; term_valid = 1'b0; term_first = 1'b0; term_last = 1'b0;
    result_ready = 1'b0; task_type = 2'd0; data_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("rst_ready", term_ready, 1);
    checkOutput("rst_valid", result_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_count", result_count, 0);
    checkOutput("rst_flight", terms_in_flight, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_proto", proto_err, 0);
    rst = 1'b1;
    @(posedge clk_in); #1;

    $display("[TB] density two terms");
    tq.delete();
    tq.push_back(mk(1, 0, 0, 0, 128, 0, 0, 0));
    tq.push_back(mk(0, 1, 0, 0, -128, 0, 0, 0));
    run_queue("dens2", 0, 0, 0, 1, 128);

    $display("[TB] force single term");
    tq.delete();
    tq.push_back(mk(1, 1, 1, 0, 128, 256, 256, 256));
    run_queue("force_neg", 0, 0, 0, 1, -256);
    tq.delete();
    tq.push_back(mk(1, 1, 1, 0, -128, 256, 256, 256));
    run_queue("force_pos", 0, 0, 0, 1, 256);

    $display("[TB] out-of-range and coincident");
    tq.delete();
    tq.push_back(mk(1, 0, 1, 0, 300, 256, 256, 256));
    tq.push_back(mk(0, 1, 1, 0, 0, 256, 256, 256));
    run_queue("range", 0, 0, 0, 1, 0);

    $display("[TB] backpressure");
    tq.delete();
    tq.push_back(mk(1, 1, 0, 0, 128, 0, 0, 0));
    foreach (tq[i]) applyStimulus(tq[i]);
    wait_result(cyc);
    checkOutput("bp_latency", cyc, 4);
    term_first = 1'b1; term_last = 1'b1; task_type = 2'd1;
    data_in = {DW'(0), DW'(128), DW'(256), DW'(256), DW'(256)};
    term_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_in); #1;
      checkOutput("bp_ready", term_ready, 0);
      checkOutput("bp_result", result, 64);
      checkOutput("bp_valid", result_valid, 1);
    end
    result_ready = 1'b1;
    @(posedge clk_in); #1;
    result_ready = 1'b0;
    checkOutput("bp_rv_fall", result_valid, 0);
    checkOutput("bp_ready_back", term_ready, 1);
    @(posedge clk_in); #1;
    term_valid = 1'b0;
    wait_result(cyc);
    checkOutput("bp_new_latency", cyc, 4);
    checkOutput("bp_new_result", result, -256);
    checkOutput("bp_new_count", result_count, 1);
    release_result("bp_new");

    $display("[TB] protocol violations");
    applyStimulus(mk(0, 0, 0, 5, 5, 0, 0, 0));
    checkOutput("orphan_proto", proto_err, 1);
    checkOutput("orphan_flight", terms_in_flight, 0);
    checkOutput("orphan_ready", term_ready, 1);
    @(posedge clk_in); #1;
    checkOutput("orphan_pulse_end", proto_err, 0);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tq.delete();
    tq.push_back(mk(1, 0, 0, 0, 64, 0, 0, 0));
    tq.push_back(mk(0, 0, 1, 0, -32, 0, 0, 0));
    tq.push_back(mk(0, 1, 3, 10, 0, 0, 0, 0));
    run_queue("abort", 0, 1, 0, 0, 0);

    $display("[TB] accumulator overflow");
    tq.delete();
    for (int k = 0; k < 128; k++) tq.push_back(mk(k == 0, k == 127, 0, 100, 100, 0, 0, 0));
`ifdef SPH_PAIR_SATURATE_EN
    run_queue("sat", 0, 0, 1, 1, 32768);
`else
    run_queue("wrap", 0, 0, 1, 1, 32768);
`endif

    $display("[TB] randomized tasks");
    for (int r = 0; r < 8; r++) begin
      tq.delete();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        xi = int'($urandom_range(0, 600)) - 300;
        tq.push_back(mk(k == 0, k == n - 1, int'($urandom_range(0, 3)), xi,
                        xi + int'($urandom_range(0, 700)) - 350,
                        int'($urandom_range(0, 4000)) - 2000,
                        int'($urandom_range(0, 4000)) - 2000,
                        int'($urandom_range(0, 1023))));
      end
      run_queue($sformatf("rand%0d", r), 1, 0, 0, 0, 0);
    end

    $display("[TB] reset mid-task");
    applyStimulus(mk(1, 0, 2, 0, 10, 0, 0, 0));
    applyStimulus(mk(0, 0, 2, 0, 20, 0, 0, 0));
    applyStimulus(mk(0, 0, 2, 0, 30, 0, 0, 0));
    rst = 1'b0;
    #1;
    checkOutput("mrst_ready", term_ready, 1);
    checkOutput("mrst_valid", result_valid, 0);
    checkOutput("mrst_result", result, 0);
    checkOutput("mrst_count", result_count, 0);
    checkOutput("mrst_type", result_type, 0);
    checkOutput("mrst_flight", terms_in_flight, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_in); #1;
      if (result_valid) seen = 1'b1;
    end
    checkOutput("mrst_no_result", seen, 0);
    tq.delete();
    tq.push_back(mk(1, 0, 0, 0, 128, 0, 0, 0));
    tq.push_back(mk(0, 1, 0, 0, -128, 0, 0, 0));
    run_queue("recover", 0, 0, 0, 1, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
